// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues word fetches, and buffers returned
// words with their PCs in a 2-entry queue feeding the decoder over valid/ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic [31:0]       fetch_pc_q, fetch_pc_d;

    logic [1:0][31:0]  q_instr_q, q_instr_d;
    logic [1:0][31:0]  q_pc_q, q_pc_d;
    logic              q_head_q, q_head_d;
    logic [1:0]        q_cnt_q, q_cnt_d;

    logic [1:0][31:0]  t_pc_q, t_pc_d;
    logic [1:0]        t_stale_q, t_stale_d;
    logic              t_head_q, t_head_d;
    logic [1:0]        t_cnt_q, t_cnt_d;

    logic              pop, issue, rsp, keep;
    logic              q_wr, t_wr;
    logic [2:0]        credits_used;

    assign pop          = o_instr_valid & i_instr_ready;
    // Entries in the queue plus words in flight may never exceed the queue depth,
    // so every response is guaranteed a slot; a same-cycle pop frees one credit.
    assign credits_used = {1'b0, q_cnt_q} + {1'b0, t_cnt_q} - {2'b00, pop};
    assign o_imem_req   = i_rst_n & ~i_redirect & (credits_used < 3'd2);
    assign o_imem_addr  = fetch_pc_q;
    assign issue        = o_imem_req & i_imem_gnt;
    assign rsp          = i_imem_rvalid & (t_cnt_q != 2'd0);
    assign keep         = rsp & ~t_stale_q[t_head_q] & ~i_redirect;
    assign q_wr         = q_head_q ^ q_cnt_q[0];
    assign t_wr         = t_head_q ^ t_cnt_q[0];

    assign o_instr_valid = (q_cnt_q != 2'd0);
    assign o_instr       = o_instr_valid ? q_instr_q[q_head_q] : 32'h0000_0013;
    assign o_pc          = o_instr_valid ? q_pc_q[q_head_q] : 32'h0000_0000;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;
        q_head_d   = q_head_q;
        q_cnt_d    = q_cnt_q + {1'b0, keep} - {1'b0, pop};
        t_pc_d     = t_pc_q;
        t_stale_d  = t_stale_q;
        t_head_d   = t_head_q;
        t_cnt_d    = t_cnt_q + {1'b0, issue} - {1'b0, rsp};

        if (issue) begin
            t_pc_d[t_wr]    = fetch_pc_q;
            t_stale_d[t_wr] = 1'b0;
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end
        if (rsp) begin
            t_head_d = ~t_head_q;
        end
        if (keep) begin
            q_instr_d[q_wr] = i_imem_rdata;
            q_pc_d[q_wr]    = t_pc_q[t_head_q];
        end
        if (pop) begin
            q_head_d = ~q_head_q;
        end
        // Issue never coincides with a redirect, so marking both tracker slots
        // stale only affects words still owed by memory.
        if (i_redirect) begin
            q_cnt_d    = '0;
            t_stale_d  = '1;
            fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_PC;
            q_instr_q  <= '0;
            q_pc_q     <= '0;
            q_head_q   <= 1'b0;
            q_cnt_q    <= '0;
            t_pc_q     <= '0;
            t_stale_q  <= '0;
            t_head_q   <= 1'b0;
            t_cnt_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            q_instr_q  <= q_instr_d;
            q_pc_q     <= q_pc_d;
            q_head_q   <= q_head_d;
            q_cnt_q    <= q_cnt_d;
            t_pc_q     <= t_pc_d;
            t_stale_q  <= t_stale_d;
            t_head_q   <= t_head_d;
            t_cnt_q    <= t_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order fixed-latency memory whose
// word at address A is A + 0x1000_0000.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n, req, gnt, rvalid, redirect, ivalid, ready;
    logic [31:0] addr, rdata, redirect_pc, instr, pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] due;
    } pend_t;

    pend_t       pend[$];
    int unsigned cyc, lat, n_cmp, n_err;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_instr_valid (ivalid),
        .i_instr_ready (ready),
        .o_instr       (instr),
        .o_pc          (pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] p,
                              input logic [31:0] w);
        chk({tag, ".valid"}, {31'd0, ivalid}, {31'd0, v});
        chk({tag, ".pc"}, pc, v ? p : 32'h0);
        chk({tag, ".instr"}, instr, v ? w : 32'h0000_0013);
    endtask

    task automatic expect_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'd0, req}, {31'd0, r});
        if (r) chk({tag, ".addr"}, addr, a);
    endtask

    // One clock: record a grant, advance, then present any due memory response.
    task automatic nx();
        if (rst_n && req && gnt) pend.push_back('{pc: addr, due: cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
        redirect = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        if (!rst_n) begin
            pend.delete();
        end else if (pend.size() != 0 && pend[0].due == cyc) begin
            rvalid = 1'b1;
            rdata  = pend[0].pc + 32'h1000_0000;
            void'(pend.pop_front());
        end
        #1;
    endtask

    task automatic restart(input int unsigned latency);
        rst_n = 1'b0;
        #1;
        nx();
        lat   = latency;
        rst_n = 1'b1;
        cyc   = 1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; gnt = 1'b1; ready = 1'b1; redirect = 1'b0;
        redirect_pc = '0; rvalid = 1'b0; rdata = '0;
        lat = 1; cyc = 0; n_cmp = 0; n_err = 0;
        #1;
        expect_req("RST", 1'b0, 32'h0);
        expect_out("RST", 1'b0, 32'h0, 32'h0);
        nx(); nx();

        // Reset release and streaming with 1-cycle memory
        rst_n = 1'b1; cyc = 1; #1;
        expect_req("A1", 1'b1, 32'h100);
        expect_out("A1", 1'b0, 32'h0, 32'h0);
        nx(); expect_req("A2", 1'b1, 32'h104);
        expect_out("A2", 1'b0, 32'h0, 32'h0);
        nx(); expect_out("A3", 1'b1, 32'h100, 32'h1000_0100);
        expect_req("A3", 1'b1, 32'h108);
        nx(); expect_out("A4", 1'b1, 32'h104, 32'h1000_0104);
        nx(); expect_out("A5", 1'b1, 32'h108, 32'h1000_0108);

        // Backpressure, drain, then grant stall
        rst_n = 1'b0; #1; nx();
        ready = 1'b0; rst_n = 1'b1; cyc = 1; #1;
        expect_req("B1", 1'b1, 32'h100);
        nx(); expect_req("B2", 1'b1, 32'h104);
        nx(); expect_out("B3", 1'b1, 32'h100, 32'h1000_0100); expect_req("B3", 1'b0, 32'h0);
        nx(); expect_out("B4", 1'b1, 32'h100, 32'h1000_0100); expect_req("B4", 1'b0, 32'h0);
        nx(); expect_out("B5", 1'b1, 32'h100, 32'h1000_0100); expect_req("B5", 1'b0, 32'h0);
        nx(); ready = 1'b1; #1;
        expect_out("B6", 1'b1, 32'h100, 32'h1000_0100); expect_req("B6", 1'b1, 32'h108);
        nx(); gnt = 1'b0; #1;
        expect_out("B7", 1'b1, 32'h104, 32'h1000_0104); expect_req("B7", 1'b1, 32'h10C);
        nx(); expect_out("B8", 1'b1, 32'h108, 32'h1000_0108); expect_req("B8", 1'b1, 32'h10C);
        nx(); expect_out("B9", 1'b0, 32'h0, 32'h0); expect_req("B9", 1'b1, 32'h10C);
        nx(); expect_req("B10", 1'b1, 32'h10C);
        nx(); gnt = 1'b1; #1; expect_req("B11", 1'b1, 32'h10C);
        nx(); expect_req("B12", 1'b1, 32'h110);
        nx(); expect_out("B13", 1'b1, 32'h10C, 32'h1000_010C);
        nx(); ready = 1'b0; #1;
        expect_out("B14", 1'b1, 32'h110, 32'h1000_0110); expect_req("B14", 1'b0, 32'h0);
        nx(); expect_out("B15", 1'b1, 32'h110, 32'h1000_0110); expect_req("B15", 1'b0, 32'h0);

        // Asynchronous reset while two words are buffered
        rst_n = 1'b0; #1;
        expect_out("C0", 1'b0, 32'h0, 32'h0); expect_req("C0", 1'b0, 32'h0);
        nx(); ready = 1'b1; rst_n = 1'b1; cyc = 1; #1;
        expect_req("C1", 1'b1, 32'h100);
        nx(); expect_req("C2", 1'b1, 32'h104);
        nx(); expect_out("C3", 1'b1, 32'h100, 32'h1000_0100);

        // Redirect with two requests in flight on 3-cycle memory
        restart(3);
        expect_req("D1", 1'b1, 32'h100);
        nx(); expect_req("D2", 1'b1, 32'h104);
        nx(); expect_req("D3", 1'b0, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h203; #1;
        expect_req("D3r", 1'b0, 32'h0);
        nx(); expect_out("D4", 1'b0, 32'h0, 32'h0); expect_req("D4", 1'b0, 32'h0);
        nx(); expect_out("D5", 1'b0, 32'h0, 32'h0); expect_req("D5", 1'b1, 32'h200);
        nx(); expect_out("D6", 1'b0, 32'h0, 32'h0); expect_req("D6", 1'b1, 32'h204);
        nx(); expect_out("D7", 1'b0, 32'h0, 32'h0); expect_req("D7", 1'b0, 32'h0);
        nx(); expect_out("D8", 1'b0, 32'h0, 32'h0);
        nx(); expect_out("D9", 1'b1, 32'h200, 32'h1000_0200);
        nx(); expect_out("D10", 1'b1, 32'h204, 32'h1000_0204);

        // Redirect coincident with rvalid and pop, target wraps the PC
        restart(1);
        expect_req("E1", 1'b1, 32'h100);
        nx(); expect_req("E2", 1'b1, 32'h104);
        nx(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        expect_out("E3", 1'b1, 32'h100, 32'h1000_0100); expect_req("E3", 1'b0, 32'h0);
        nx(); expect_out("E4", 1'b0, 32'h0, 32'h0); expect_req("E4", 1'b1, 32'hFFFF_FFFC);
        nx(); expect_out("E5", 1'b0, 32'h0, 32'h0); expect_req("E5", 1'b1, 32'h0000_0000);
        nx(); expect_out("E6", 1'b1, 32'hFFFF_FFFC, 32'h0FFF_FFFC);
        nx(); expect_out("E7", 1'b1, 32'h0000_0000, 32'h1000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
